turn_sequencer: RTL
===================

Name: turn_sequencer

Overview:
- Control FSM that sequences one networked Go game per board.
- Accepts local moves, starts board_updater and waits for its result, then fires the UART tx for the new board and waits for the opponent's board on rx.
- Tracks whose turn it is and detects game end on two consecutive passes.
- Sits between game-level inputs (switches, move entry) and the board_updater, tx and rx blocks; runs on clk_65mhz.

Parameters:
- TX_CYCLES, 1_408_368: cycles tx_trigger blocks further sends; PKT_LEN*DIVISOR (208*6771).
- RX_TIMEOUT, 130_000_000: cycles in REMOTE_WAIT before retransmit (2 s at 65 MHz). Used only with RX_TIMEOUT_EN.
- MAX_RETRIES, 3: retransmits before link error. Used only with RX_TIMEOUT_EN.

Ports:
- clk_in  input  1  system clock (clk_65mhz).
- rst_in  input  1  synchronous, active-high reset.
- start_in  input  1  debounced level; rising edge starts a game from IDLE.
- local_black  input  1  1 = local player is black (moves first); sampled on start.
- move_avail  input  1  local move valid strobe.
- move_in  input  8  [7:4] row, [3:0] col, each 0-8; 8'hFF = pass.
- board_ready  input  1  board_updater done.
- rx_ready  input  1  rx packet received (one-cycle pulse).
- rx_pass  input  1  received packet is a pass; valid with rx_ready.
- upd_start  output  1  one-cycle start pulse to board_updater.
- upd_move  output  8  move held for board_updater.
- turn  output  1  colour being placed, 1 = black.
- tx_trigger  output  1  one-cycle pulse to tx.
- my_turn  output  1  high only in LOCAL_WAIT.
- illegal_move  output  1  one-cycle pulse on a rejected move.
- game_over  output  1  level, held until reset.
- link_err  output  1  level, held until reset.
- state_out  output  3  current state encoding, for debug LEDs.

Behaviour:
- Reset: state IDLE. All outputs 0, except upd_move = 8'h00. Pass streak, retry and cycle counters cleared.
- Reset mid-operation has the same effect, and takes effect the cycle after rst_in is sampled high. In-flight tx/updater work is not aborted; those blocks share rst_in.
- All outputs are registered.
- States and state_out codes: IDLE=0, LOCAL_WAIT=1, UPDATE=2, TX=3, REMOTE_WAIT=4, GAME_OVER=5, ERROR=6.
- IDLE: on a start_in rising edge (previous-cycle register), latch local_black into turn.
  - Go to LOCAL_WAIT if local_black = 1, else REMOTE_WAIT.
  - start_in is ignored in every other state.
- LOCAL_WAIT: my_turn=1. move_avail is accepted in the sampling cycle.
  - move_in = 8'hFF (pass): pass streak +1. If the streak reaches 2, go to GAME_OVER; otherwise go to TX.
  - Row or col > 8 (except 8'hFF): illegal_move pulses next cycle; stay in LOCAL_WAIT.
  - Legal move: upd_move <= move_in, upd_start=1 for exactly the first cycle of UPDATE, pass streak cleared.
- UPDATE: board_ready is ignored during the upd_start cycle. The first board_ready afterwards goes to TX. No timeout.
- TX: tx_trigger=1 in the first cycle of TX only. A counter then runs TX_CYCLES cycles, after which the state goes to REMOTE_WAIT.
  - Total TX dwell = TX_CYCLES cycles after the trigger cycle.
- REMOTE_WAIT: on rx_ready:
  - rx_pass=1: streak +1; if the streak reaches 2, go to GAME_OVER, else LOCAL_WAIT.
  - rx_pass=0: streak cleared; go to LOCAL_WAIT.
- turn holds the local colour for the whole game. The remote board arrives complete, so the updater only ever places local stones.
- GAME_OVER: game_over=1. ERROR: link_err=1. Both are absorbing until rst_in.
- Inputs outside their accepting state are ignored: move_avail outside LOCAL_WAIT, rx_ready outside REMOTE_WAIT, board_ready outside UPDATE. These are dropped with no side effects.
- Simultaneous rx_ready and move_avail: only the input belonging to the current state is acted on.
- Counters are sized by $clog2 of their parameter. No wrap-around is possible because each counter is cleared on state entry.

Optional Feature:
- Macro RX_TIMEOUT_EN.
- Defined: a wait counter runs in REMOTE_WAIT and clears on entry.
  - Reaching RX_TIMEOUT with retries < MAX_RETRIES: retries +1, go to TX (retransmit with a new tx_trigger).
  - Reaching RX_TIMEOUT with retries = MAX_RETRIES: go to ERROR.
  - retries clears on any accepted rx_ready.
  - rx_ready in the same cycle as the timeout wins.
- Undefined: REMOTE_WAIT waits indefinitely, no counter logic is built, and link_err is tied 0.

Test Plan (override TX_CYCLES=10, RX_TIMEOUT=50, MAX_RETRIES=2):
- Reset, local_black=1, start_in rise -> state_out=1, my_turn=1, turn=1, all pulses 0.
- move_in=8'h41 with move_avail -> upd_start high exactly 1 cycle, upd_move=8'h41; board_ready 3 cycles later -> tx_trigger 1 cycle; REMOTE_WAIT after 10 further cycles.
- move_in=8'h92 (row 9) -> illegal_move 1-cycle pulse, state stays 1, no upd_start.
- Local pass 8'hFF then rx_ready with rx_pass=1 -> game_over=1, state_out=5, held; later move_avail/rx_ready give no change.
- RX_TIMEOUT_EN, no rx_ready -> tx_trigger at 3 instances total (1+2 retries), then link_err=1, state_out=6; repeat with rx_ready on the 50th wait cycle -> LOCAL_WAIT, no retransmit.
- Assert rst_in during TX count and during UPDATE -> next cycle state_out=0, all outputs 0; local_black=0 start -> state_out=4.

Source files
------------

// File: rtl/turn_sequencer.sv
// Turn sequencer for one networked Go game: local move entry, board update, tx, then wait for the opponent.
// Optional macro RX_TIMEOUT_EN adds the REMOTE_WAIT timeout / retransmit / link-error path.
module turn_sequencer #(
  parameter int TX_CYCLES   = 1_408_368,
  parameter int RX_TIMEOUT  = 130_000_000,
  parameter int MAX_RETRIES = 3
) (
  input  logic       clk_in,
  input  logic       rst_in,
  input  logic       start_in,
  input  logic       local_black,
  input  logic       move_avail,
  input  logic [7:0] move_in,
  input  logic       board_ready,
  input  logic       rx_ready,
  input  logic       rx_pass,
  output logic       upd_start,
  output logic [7:0] upd_move,
  output logic       turn,
  output logic       tx_trigger,
  output logic       my_turn,
  output logic       illegal_move,
  output logic       game_over,
  output logic       link_err,
  output logic [2:0] state_out
);

  localparam logic [2:0] IDLE        = 3'd0;
  localparam logic [2:0] LOCAL_WAIT  = 3'd1;
  localparam logic [2:0] UPDATE      = 3'd2;
  localparam logic [2:0] TX          = 3'd3;
  localparam logic [2:0] REMOTE_WAIT = 3'd4;
  localparam logic [2:0] GAME_OVER   = 3'd5;
  localparam logic [2:0] ERROR       = 3'd6;

  localparam int TXW = $clog2(TX_CYCLES + 1);
  localparam logic [TXW-1:0] TX_LAST = TXW'(TX_CYCLES);
  localparam logic [7:0] PASS_MOVE = 8'hFF;

  logic [2:0]     state_q, state_d;
  logic           start_prev_q;
  logic [1:0]     streak_q, streak_d;
  logic [TXW-1:0] tx_cnt_q, tx_cnt_d;
  logic [7:0]     upd_move_q, upd_move_d;
  logic           turn_q, turn_d;
  logic           upd_start_q, upd_start_d;
  logic           illegal_q, illegal_d;
  logic           tx_trigger_q, my_turn_q, game_over_q;

`ifdef RX_TIMEOUT_EN
  localparam int WW = $clog2(RX_TIMEOUT);
  localparam int RW = $clog2(MAX_RETRIES + 1);
  localparam logic [WW-1:0] WAIT_LAST = WW'(RX_TIMEOUT - 1);
  localparam logic [RW-1:0] RETRY_MAX = RW'(MAX_RETRIES);

  logic [WW-1:0] wait_cnt_q, wait_cnt_d;
  logic [RW-1:0] retry_q, retry_d;
  logic          link_err_q;
`endif

  always_comb begin
    state_d     = state_q;
    streak_d    = streak_q;
    tx_cnt_d    = '0;
    upd_move_d  = upd_move_q;
    turn_d      = turn_q;
    upd_start_d = 1'b0;
    illegal_d   = 1'b0;
`ifdef RX_TIMEOUT_EN
    wait_cnt_d  = '0;
    retry_d     = retry_q;
`endif
    case (state_q)
      IDLE: begin
        if (start_in && !start_prev_q) begin
          turn_d  = local_black;
          state_d = local_black ? LOCAL_WAIT : REMOTE_WAIT;
        end
      end
      LOCAL_WAIT: begin
        if (move_avail) begin
          if (move_in == PASS_MOVE) begin
            streak_d = streak_q + 2'd1;
            state_d  = (streak_q == 2'd1) ? GAME_OVER : TX;
          end else if (move_in[7:4] > 4'd8 || move_in[3:0] > 4'd8) begin
            illegal_d = 1'b1;
          end else begin
            upd_move_d  = move_in;
            upd_start_d = 1'b1;
            streak_d    = 2'd0;
            state_d     = UPDATE;
          end
        end
      end
      UPDATE: begin
        // The updater cannot be done in the cycle it is being started.
        if (board_ready && !upd_start_q) state_d = TX;
      end
      TX: begin
        if (tx_cnt_q == TX_LAST) state_d = REMOTE_WAIT;
        else tx_cnt_d = tx_cnt_q + TXW'(1);
      end
      REMOTE_WAIT: begin
        if (rx_ready) begin
`ifdef RX_TIMEOUT_EN
          retry_d = '0;
`endif
          if (rx_pass) begin
            streak_d = streak_q + 2'd1;
            state_d  = (streak_q == 2'd1) ? GAME_OVER : LOCAL_WAIT;
          end else begin
            streak_d = 2'd0;
            state_d  = LOCAL_WAIT;
          end
        end
`ifdef RX_TIMEOUT_EN
        else if (wait_cnt_q == WAIT_LAST) begin
          if (retry_q == RETRY_MAX) begin
            state_d = ERROR;
          end else begin
            retry_d = retry_q + RW'(1);
            state_d = TX;
          end
        end else begin
          wait_cnt_d = wait_cnt_q + WW'(1);
        end
`endif
      end
      default: ;  // GAME_OVER and ERROR hold until reset
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q      <= IDLE;
      start_prev_q <= 1'b0;
      streak_q     <= 2'd0;
      tx_cnt_q     <= '0;
      upd_move_q   <= 8'h00;
      turn_q       <= 1'b0;
      upd_start_q  <= 1'b0;
      illegal_q    <= 1'b0;
      tx_trigger_q <= 1'b0;
      my_turn_q    <= 1'b0;
      game_over_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      start_prev_q <= start_in;
      streak_q     <= streak_d;
      tx_cnt_q     <= tx_cnt_d;
      upd_move_q   <= upd_move_d;
      turn_q       <= turn_d;
      upd_start_q  <= upd_start_d;
      illegal_q    <= illegal_d;
      tx_trigger_q <= (state_d == TX) && (state_q != TX);
      my_turn_q    <= (state_d == LOCAL_WAIT);
      game_over_q  <= (state_d == GAME_OVER);
    end
  end

`ifdef RX_TIMEOUT_EN
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      wait_cnt_q <= '0;
      retry_q    <= '0;
      link_err_q <= 1'b0;
    end else begin
      wait_cnt_q <= wait_cnt_d;
      retry_q    <= retry_d;
      link_err_q <= (state_d == ERROR);
    end
  end

  assign link_err = link_err_q;
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^{RX_TIMEOUT[0], MAX_RETRIES[0]};
  assign link_err = 1'b0;
`endif

  assign upd_start    = upd_start_q;
  assign upd_move     = upd_move_q;
  assign turn         = turn_q;
  assign tx_trigger   = tx_trigger_q;
  assign my_turn      = my_turn_q;
  assign illegal_move = illegal_q;
  assign game_over    = game_over_q;
  assign state_out    = state_q;

endmodule
